struct_rr_arbiter: RTL and testbench

STRUCT_RR_ARBITER -- requirements
Module: struct_rr_arbiter

---
 rtl/struct_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_struct_rr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/struct_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : struct_rr_arbiter
// Brief    : Two-source round-robin arbiter for structured payloads, with
//            source lock-in and a one-deep registered output stage.
// Revision : 1.0 - initial release
// ============================================================================

package struct_rr_arbiter_pkg;
    typedef struct packed {
        logic [3:0] part_a;
        logic [1:0] part_b;
    } packed_struct_t;
endpackage

module struct_rr_arbiter
    import struct_rr_arbiter_pkg::*;
#(
    parameter int         CNT_W     = 4,
    parameter logic [1:0] LOCK_CODE = 2'b11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                in_valid,
    output logic [1:0]                in_ready,
    input  packed_struct_t [1:0]      in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output packed_struct_t            out_data,
    output logic                      out_src,
    output logic [1:0][CNT_W-1:0]     grant_cnt,
    output logic                      locked
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOCK0 = 2'd1;
    localparam logic [1:0] c_ST_LOCK1 = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last_winner;
    logic             r_out_valid;
    packed_struct_t   r_out_data;
    logic             r_out_src;
    logic [CNT_W-1:0] r_cnt [2];

    logic             w_free;
    logic [1:0]       w_in_ready;
    logic             w_locked;
    logic             w_xfer;
    logic             w_src;

    assign w_free = !r_out_valid || out_ready;
    assign w_xfer = |(in_valid & w_in_ready);
    // At most one ready bit is ever set, so the upper bit names the source.
    assign w_src  = w_in_ready[1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: any accepted transfer decides lock entry or release.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            if (in_data[w_src].part_b == LOCK_CODE) begin
                w_state_nxt = w_src ? c_ST_LOCK1 : c_ST_LOCK0;
            end else begin
                w_state_nxt = c_ST_IDLE;
            end
        end
    end

    // Output logic: grant selection and lock indication.
    always_comb begin
        w_in_ready = 2'b00;
        w_locked   = (r_state == c_ST_LOCK0) || (r_state == c_ST_LOCK1);
        if (rst_n && w_free) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (&in_valid) begin
                        w_in_ready = r_last_winner ? 2'b01 : 2'b10;
                    end else begin
                        w_in_ready = in_valid;
                    end
                end
                c_ST_LOCK0: w_in_ready = {1'b0, in_valid[0]};
                c_ST_LOCK1: w_in_ready = {in_valid[1], 1'b0};
                default:    w_in_ready = 2'b00;
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign locked   = w_locked;

    // Output register and round-robin history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_src     <= 1'b0;
            r_last_winner <= 1'b1;
        end else if (w_xfer) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= in_data[w_src];
            r_out_src     <= w_src;
            r_last_winner <= w_src;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt[gi] <= '0;
                end else if (in_valid[gi] && w_in_ready[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                end
            end
            assign grant_cnt[gi] = r_cnt[gi];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_struct_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_struct_rr_arbiter
// Brief    : Directed self-checking bench for struct_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================

module tb_struct_rr_arbiter;
    import struct_rr_arbiter_pkg::*;

    localparam int c_CNT_W = 4;

    logic                       clk;
    logic                       rst_n;
    logic [1:0]                 in_valid;
    logic [1:0]                 in_ready;
    packed_struct_t [1:0]       in_data;
    logic                       out_valid;
    logic                       out_ready;
    packed_struct_t             out_data;
    logic                       out_src;
    logic [1:0][c_CNT_W-1:0]    grant_cnt;
    logic                       locked;

    int n_checks = 0;
    int n_errors = 0;

    struct_rr_arbiter #(.CNT_W(c_CNT_W), .LOCK_CODE(2'b11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant_cnt (grant_cnt),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic packed_struct_t mk(input logic [3:0] a, input logic [1:0] b);
        packed_struct_t s;
        s.part_a = a;
        s.part_b = b;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so inputs and outputs are read mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 2'b11;
        out_ready = 1'b0;
        in_data[0] = mk(4'h0, 2'b00);
        in_data[1] = mk(4'h0, 2'b00);
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_src",   32'(out_src),   32'h0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);
        chk("rst_locked",    32'(locked),    32'h0);

        // Contention: alternating grants starting with source 0
        rst_n      = 1'b1;
        out_ready  = 1'b1;
        in_data[0] = mk(4'h1, 2'b00);
        in_data[1] = mk(4'h2, 2'b00);
        #1;
        chk("cont_first_ready", 32'(in_ready), 32'h1);
        tick();
        chk("cont_src0", 32'(out_src), 32'h0);
        chk("cont_data0", 32'(out_data), 32'h04);
        chk("cont_ready1", 32'(in_ready), 32'h2);
        tick();
        chk("cont_src1", 32'(out_src), 32'h1);
        chk("cont_data1", 32'(out_data), 32'h08);
        chk("cont_valid1", 32'(out_valid), 32'h1);
        tick();
        chk("cont_src2", 32'(out_src), 32'h0);
        chk("cont_valid2", 32'(out_valid), 32'h1);
        tick();
        chk("cont_src3", 32'(out_src), 32'h1);
        chk("cont_valid3", 32'(out_valid), 32'h1);
        chk("cont_cnt", 32'(grant_cnt), 32'h22);

        // Backpressure: output held stable, no grants while stalled
        in_valid   = 2'b01;
        in_data[0] = mk(4'hA, 2'b01);
        tick();
        chk("bp_load", 32'(out_data), 32'h29);
        out_ready = 1'b0;
        in_valid  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("bp_out_data", 32'(out_data), 32'h29);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h2);
        tick();
        chk("bp_release_src", 32'(out_src), 32'h1);
        chk("bp_cnt", 32'(grant_cnt), 32'h33);

        // Lock on source 0 with source 1 contending
        in_data[0] = mk(4'h3, 2'b11);
        in_data[1] = mk(4'h4, 2'b00);
        #1;
        chk("lk_ready0", 32'(in_ready), 32'h1);
        chk("lk_unlocked", 32'(locked), 32'h0);
        tick();
        chk("lk_src_a", 32'(out_src), 32'h0);
        chk("lk_locked", 32'(locked), 32'h1);
        chk("lk_ready_locked", 32'(in_ready), 32'h1);
        in_data[0] = mk(4'h5, 2'b00);
        tick();
        chk("lk_src_b", 32'(out_src), 32'h0);
        chk("lk_data_b", 32'(out_data), 32'h14);
        chk("lk_released", 32'(locked), 32'h0);
        tick();
        chk("lk_src_c", 32'(out_src), 32'h1);
        chk("lk_data_c", 32'(out_data), 32'h10);
        chk("lk_cnt", 32'(grant_cnt), 32'h45);

        // Lock on source 1, then owner goes idle
        in_valid   = 2'b10;
        in_data[1] = mk(4'h6, 2'b11);
        #1;
        chk("li_ready", 32'(in_ready), 32'h2);
        tick();
        chk("li_locked", 32'(locked), 32'h1);
        chk("li_src", 32'(out_src), 32'h1);
        in_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("li_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("li_drained", 32'(out_valid), 32'h0);
            chk("li_still_locked", 32'(locked), 32'h1);
        end
        chk("li_data_hold", 32'(out_data), 32'h1B);
        chk("li_src_hold", 32'(out_src), 32'h1);
        in_valid   = 2'b11;
        in_data[1] = mk(4'h7, 2'b00);
        #1;
        chk("li_owner_ready", 32'(in_ready), 32'h2);
        tick();
        chk("li_owner_src", 32'(out_src), 32'h1);
        chk("li_owner_data", 32'(out_data), 32'h1C);
        chk("li_unlocked", 32'(locked), 32'h0);
        chk("li_cnt", 32'(grant_cnt), 32'h65);

        // Counter wrap: source 0 count goes 5 -> 15 -> 0
        in_valid   = 2'b01;
        in_data[0] = mk(4'h9, 2'b10);
        for (int i = 0; i < 10; i++) tick();
        chk("wrap_15", 32'(grant_cnt), 32'h6F);
        tick();
        chk("wrap_0", 32'(grant_cnt), 32'h60);

        // Reset during LOCK0 with a pending output transfer
        in_data[0] = mk(4'hC, 2'b11);
        tick();
        chk("rl_locked", 32'(locked), 32'h1);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rl_in_ready", 32'(in_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        chk("rl_out_valid", 32'(out_valid), 32'h0);
        chk("rl_unlocked", 32'(locked), 32'h0);
        chk("rl_cnt", 32'(grant_cnt), 32'h0);
        in_valid  = 2'b11;
        out_ready = 1'b1;
        #1;
        chk("rl_first_ready", 32'(in_ready), 32'h1);
        tick();
        chk("rl_first_src", 32'(out_src), 32'h0);
        chk("rl_first_valid", 32'(out_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
